// File: rtl/shift_pkg.sv
// -----------------------------------------------------------------------------
// shift_pkg
// Shared definitions for the sequential right shifter:
//   - shift_state_t : controller states (IDLE, SHIFT, DONE)
//   - cnt_width()   : width of a counter able to hold 0..w, i.e. ceil(log2(w+1))
//   - SHIFT_LOGICAL / SHIFT_ARITH : encoding of the 'arith' mode input
// No ports (package).
// -----------------------------------------------------------------------------
package shift_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } shift_state_t;

  localparam logic SHIFT_LOGICAL = 1'b0;
  localparam logic SHIFT_ARITH   = 1'b1;

  // Counter width that can represent every value from 0 up to and including w.
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage : shift_pkg

// File: rtl/shift_right_stage.sv
// -----------------------------------------------------------------------------
// shift_right_stage
// Combinational one-position right step built from per-bit 2:1 mux cells.
// Ports:
//   din  [WIDTH-1:0] in  : data to step
//   fill             in  : bit shifted into the MSB position
//   en               in  : 1 = step right by one, 0 = pass din through
//   dout [WIDTH-1:0] out : stepped (or passed-through) data
// -----------------------------------------------------------------------------
module shift_right_stage
  import shift_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] din,
  input  logic             fill,
  input  logic             en,
  output logic [WIDTH-1:0] dout
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    logic shifted_in_s;

    // The MSB takes the fill bit; every other bit takes its upper neighbour.
    if (i == WIDTH - 1) begin : g_msb
      assign shifted_in_s = fill;
    end else begin : g_low
      assign shifted_in_s = din[i + 1];
    end

    assign dout[i] = en ? shifted_in_s : din[i];
  end

endmodule : shift_right_stage

// File: rtl/shift_right_seq.sv
// -----------------------------------------------------------------------------
// shift_right_seq
// Sequential right shifter: accepts operand 'a' and shift amount 'b' over a
// valid/ready handshake, shifts one bit per clock (logical or arithmetic) and
// returns the result over a second valid/ready handshake.
// Ports:
//   clk                   in  : rising-edge clock
//   rst                   in  : synchronous active-high reset
//   in_valid              in  : operand request
//   in_ready              out : idle and able to accept
//   a        [WIDTH-1:0]  in  : operand, sampled on accept
//   b        [WIDTH-1:0]  in  : unsigned shift amount, sampled on accept
//   arith                 in  : 1 = sign fill, 0 = zero fill, sampled on accept
//   out_valid             out : result available
//   out_ready             in  : consumer takes result
//   s        [WIDTH-1:0]  out : result (meaningful while out_valid = 1)
// All outputs are decoded from registered state only.
// -----------------------------------------------------------------------------
module shift_right_seq
  import shift_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             arith,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s
);

  localparam int CW = cnt_width(WIDTH);

  localparam logic [CW-1:0]  CNT_MAX   = CW'(WIDTH);
  localparam logic [CW-1:0]  CNT_ZERO  = {CW{1'b0}};
  localparam logic [CW-1:0]  CNT_ONE   = CW'(1);
  localparam logic [WIDTH:0] SAT_LIMIT = (WIDTH + 1)'(WIDTH);

  shift_state_t     state_q;
  logic [WIDTH-1:0] data_q;
  logic             fill_q;
  logic [CW-1:0]    cnt_q;

  logic [WIDTH-1:0] data_d;
  logic [CW-1:0]    cnt_load_s;
  logic             fill_load_s;
  logic             shift_en_s;

  // Clamp the shift amount so any b >= WIDTH loads exactly WIDTH (no wrap).
  always_comb begin
    cnt_load_s = CNT_ZERO;
    if ({1'b0, b} >= SAT_LIMIT) begin
      cnt_load_s = CNT_MAX;
    end else begin
      cnt_load_s = CW'(b);
    end
  end

  assign fill_load_s = (arith == SHIFT_ARITH) ? a[WIDTH-1] : 1'b0;
  assign shift_en_s  = (state_q == SHIFT);

  shift_right_stage #(
    .WIDTH (WIDTH)
  ) u_stage (
    .din  (data_q),
    .fill (fill_q),
    .en   (shift_en_s),
    .dout (data_d)
  );

  // Controller FSM plus data, fill and count registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      data_q  <= {WIDTH{1'b0}};
      fill_q  <= 1'b0;
      cnt_q   <= CNT_ZERO;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            data_q  <= a;
            fill_q  <= fill_load_s;
            cnt_q   <= cnt_load_s;
            state_q <= (cnt_load_s != CNT_ZERO) ? SHIFT : DONE;
          end else begin
            state_q <= IDLE;
          end
        end
        SHIFT: begin
          data_q <= data_d;
          cnt_q  <= cnt_q - CNT_ONE;
          // Last step: count goes 1 -> 0 on this same edge.
          if (cnt_q == CNT_ONE) begin
            state_q <= DONE;
          end else begin
            state_q <= SHIFT;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q <= IDLE;
          end else begin
            state_q <= DONE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign s         = data_q;

endmodule : shift_right_seq

// File: tb/tb_shift_right_seq.sv
module tb_shift_right_seq;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] a;
  logic [3:0] b;
  logic       arith;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] s;

  int checks;
  int errors;

  shift_right_seq #(
    .WIDTH (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .arith     (arith),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .s         (s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Starts an operation from IDLE at a negedge; returns cycles from the accept
  // cycle to the first out_valid cycle (40 means it never arrived).
  task automatic start_op(input logic [3:0] av, input logic [3:0] bv,
                          input logic ar, output int lat);
    a = av; b = bv; arith = ar; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; a = ~av; b = 4'h0; arith = ~ar;
    lat = 1;
    while (out_valid !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic handoff();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    checks++; if (s !== 4'b0000) begin errors++; $display("FAIL reset_s: got %b want 0000", s); end
    @(negedge clk);
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL reset_idle_hold: got rdy=%b vld=%b want 1/0", in_ready, out_valid); end
  endtask

  task automatic test_shift_modes();
    int lat;
    start_op(4'b1011, 4'd1, 1'b0, lat);
    checks++; if (lat !== 2) begin errors++; $display("FAIL b1_log_latency: got %0d want 2", lat); end
    checks++; if (s !== 4'b0101) begin errors++; $display("FAIL b1_log_s: got %b want 0101", s); end
    handoff();
    start_op(4'b1011, 4'd2, 1'b1, lat);
    checks++; if (lat !== 3) begin errors++; $display("FAIL b2_arith_latency: got %0d want 3", lat); end
    checks++; if (s !== 4'b1110) begin errors++; $display("FAIL b2_arith_s: got %b want 1110", s); end
    handoff();
    start_op(4'b1011, 4'd2, 1'b0, lat);
    checks++; if (lat !== 3) begin errors++; $display("FAIL b2_log_latency: got %0d want 3", lat); end
    checks++; if (s !== 4'b0010) begin errors++; $display("FAIL b2_log_s: got %b want 0010", s); end
    handoff();
    start_op(4'b0110, 4'd1, 1'b1, lat);
    checks++; if (s !== 4'b0011) begin errors++; $display("FAIL b1_arith_pos_s: got %b want 0011", s); end
    handoff();
  endtask

  task automatic test_passthrough();
    int lat;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL pass_pre_ready: got %b want 1", in_ready); end
    start_op(4'b0110, 4'd0, 1'b0, lat);
    checks++; if (lat !== 1) begin errors++; $display("FAIL pass_latency: got %0d want 1", lat); end
    checks++; if (s !== 4'b0110) begin errors++; $display("FAIL pass_s: got %b want 0110", s); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL pass_busy: got %b want 0", in_ready); end
    handoff();
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL pass_after: got rdy=%b vld=%b want 1/0", in_ready, out_valid); end
  endtask

  task automatic test_saturate();
    int lat;
    start_op(4'b1000, 4'd9, 1'b0, lat);
    checks++; if (lat !== 5) begin errors++; $display("FAIL sat_log_latency: got %0d want 5", lat); end
    checks++; if (s !== 4'b0000) begin errors++; $display("FAIL sat_log_s: got %b want 0000", s); end
    handoff();
    start_op(4'b1000, 4'd9, 1'b1, lat);
    checks++; if (lat !== 5) begin errors++; $display("FAIL sat_arith_latency: got %0d want 5", lat); end
    checks++; if (s !== 4'b1111) begin errors++; $display("FAIL sat_arith_s: got %b want 1111", s); end
    handoff();
    start_op(4'b1001, 4'd4, 1'b0, lat);
    checks++; if (lat !== 5 || s !== 4'b0000) begin errors++; $display("FAIL b4_exact: got lat=%0d s=%b want 5/0000", lat, s); end
    handoff();
    start_op(4'b0111, 4'd15, 1'b1, lat);
    checks++; if (lat !== 5 || s !== 4'b0000) begin errors++; $display("FAIL b15_arith_pos: got lat=%0d s=%b want 5/0000", lat, s); end
    handoff();
  endtask

  task automatic test_backpressure();
    int lat;
    start_op(4'b1100, 4'd3, 1'b0, lat);
    checks++; if (lat !== 4) begin errors++; $display("FAIL bp_latency: got %0d want 4", lat); end
    a = 4'b0011; b = 4'd1; arith = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      checks++; if (out_valid !== 1'b1 || s !== 4'b0001 || in_ready !== 1'b0) begin errors++; $display("FAIL bp_stall%0d: got vld=%b s=%b rdy=%b want 1/0001/0", i, out_valid, s, in_ready); end
      @(negedge clk);
    end
    checks++; if (out_valid !== 1'b1 || s !== 4'b0001) begin errors++; $display("FAIL bp_hold_end: got vld=%b s=%b want 1/0001", out_valid, s); end
    handoff();
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL bp_after_handoff: got vld=%b rdy=%b want 0/1", out_valid, in_ready); end
    @(negedge clk);
    in_valid = 1'b0; a = 4'b1111; b = 4'd0;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_next_accept: got rdy=%b want 0", in_ready); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b1 || s !== 4'b0001) begin errors++; $display("FAIL bp_next_result: got vld=%b s=%b want 1/0001", out_valid, s); end
    handoff();
  endtask

  task automatic test_reset_mid();
    int lat;
    int seen;
    a = 4'b1010; b = 4'd3; arith = 1'b1; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    rst = 1'b0; out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || s !== 4'b0000) begin errors++; $display("FAIL midrst_state: got vld=%b rdy=%b s=%b want 0/1/0000", out_valid, in_ready, s); end
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (out_valid === 1'b1) seen++;
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL midrst_no_result: got %0d valid cycles want 0", seen); end
    start_op(4'b1111, 4'd1, 1'b0, lat);
    checks++; if (lat !== 2 || s !== 4'b0111) begin errors++; $display("FAIL midrst_fresh: got lat=%0d s=%b want 2/0111", lat, s); end
    handoff();
  endtask

  initial begin
    checks = 0; errors = 0;
    rst = 1'b1; in_valid = 1'b0; a = 4'h0; b = 4'h0; arith = 1'b0; out_ready = 1'b0;
    test_reset();
    test_shift_modes();
    test_passthrough();
    test_saturate();
    test_backpressure();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule : tb_shift_right_seq
